// File: rtl/ft_replay_if.sv
// ft_replay_if: error/replay handshake and status bundle between controller and its neighbours
interface ft_replay_if #(
  parameter int ADDR_WIDTH  = 5,
  parameter int RETRY_WIDTH = 2
);
  logic                   error_i;
  logic                   replay_ready_i;
  logic                   replay_valid_o;
  logic [ADDR_WIDTH-1:0]  replay_addr_o;
  logic                   fetch_block_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   fatal_o;
  logic [RETRY_WIDTH-1:0] retry_cnt_o;
  modport master (
    input  error_i, replay_ready_i,
    output replay_valid_o, replay_addr_o, fetch_block_o, busy_o, done_o, fatal_o, retry_cnt_o
  );
  modport slave (
    output error_i, replay_ready_i,
    input  replay_valid_o, replay_addr_o, fetch_block_o, busy_o, done_o, fatal_o, retry_cnt_o
  );
endinterface

// File: rtl/ft_replay_control.sv
// ft_replay_control: blocks fetch and walks register addresses for checkpoint replay, with bounded retry
module ft_replay_control #(
  parameter int ADDR_WIDTH  = 5,
  parameter int NUM_REG     = 2**ADDR_WIDTH,
  parameter int SKIP_ZERO   = 0,
  parameter int MAX_RETRY   = 2,
  parameter int RETRY_WIDTH = $clog2(MAX_RETRY+1)
) (
  input logic clk,
  input logic rst,
  ft_replay_if.master bus
);
  typedef enum logic [1:0] {IDLE, REPLAY, DONE, FATAL} state_t;
  localparam logic [ADDR_WIDTH-1:0]  START = ADDR_WIDTH'(SKIP_ZERO);
  localparam logic [ADDR_WIDTH-1:0]  LAST  = ADDR_WIDTH'(NUM_REG-1);
  localparam logic [RETRY_WIDTH-1:0] RMAX  = RETRY_WIDTH'(MAX_RETRY);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [RETRY_WIDTH-1:0] retry, retry_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr  <= START;
      retry <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      retry <= retry_n;
    end
  end
  // An error in REPLAY outranks a same-edge transfer; FATAL freezes addr and retry
  always_comb begin
    state_n = state;
    addr_n  = addr;
    retry_n = retry;
    case (state)
      IDLE, DONE: begin
        state_n = bus.error_i ? REPLAY : IDLE;
        addr_n  = START;
        retry_n = '0;
      end
      REPLAY: begin
        if (bus.error_i) begin
          if (retry == RMAX) state_n = FATAL;
          else begin
            retry_n = retry + 1'b1;
            addr_n  = START;
          end
        end else if (bus.replay_ready_i) begin
          if (addr == LAST) state_n = DONE;
          else addr_n = addr + 1'b1;
        end
      end
      default: ;
    endcase
  end
  assign bus.replay_valid_o = state == REPLAY;
  assign bus.replay_addr_o  = addr;
  assign bus.fetch_block_o  = state != IDLE;
  assign bus.busy_o         = state != IDLE;
  assign bus.done_o         = state == DONE;
  assign bus.fatal_o        = state == FATAL;
  assign bus.retry_cnt_o    = retry;
endmodule
